// File: rtl/i2c_target_controller_if.sv
// Signal bundle between the I2C target engine, the pad drivers and the register-side logic.
interface i2c_target_controller_if;
   logic       scl_in;
   logic       sda_in;
   logic       scl_drive_low;
   logic       sda_drive_low;
   logic [6:0] own_address;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_taken;
   logic       tx_underrun;
   logic       busy;
   logic       addressed;
   logic       is_read;

   modport slave (
      input  scl_in, sda_in, own_address, tx_data, tx_valid,
      output scl_drive_low, sda_drive_low, rx_data, rx_valid, tx_taken, tx_underrun,
             busy, addressed, is_read
   );

   modport master (
      output scl_in, sda_in, own_address, tx_data, tx_valid,
      input  scl_drive_low, sda_drive_low, rx_data, rx_valid, tx_taken, tx_underrun,
             busy, addressed, is_read
   );
endinterface

// File: rtl/i2c_target_controller.sv
// I2C target engine: oversampled SCL/SDA, START/STOP detect, 7-bit address match, byte handshake.
// Define I2C_TARGET_STRETCH_EN to stretch SCL on a read underrun instead of sending 0xFF.
module i2c_target_controller #(
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   n_rst,
   i2c_target_controller_if.slave bus
);
   // state      | meaning
   // IDLE       | bus free, waiting for START
   // ADDR       | shifting in address and R/W bit
   // ADDR_ACK   | driving the address ACK bit
   // RX_BYTE    | shifting in a write byte
   // RX_ACK     | driving the write-data ACK bit
   // TX_LOAD    | fetching the next read byte
   // TX_BYTE    | shifting out a read byte
   // TX_ACK     | sampling the controller ACK/NACK
   // WAIT_STOP  | not ours or NACKed, wait for START/STOP
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK,
      S_TX_LOAD, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   state_t                 state_q, state_d;
   logic [7:0]             shift_q, shift_d;
   logic [2:0]             cnt_q, cnt_d;
   logic                   ack_ph_q, ack_ph_d;
   logic                   sda_drv_q, sda_drv_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   tx_taken_q, tx_taken_d;
   logic                   tx_underrun_q, tx_underrun_d;
   logic                   busy_q, busy_d;
   logic                   addressed_q, addressed_d;
   logic                   is_read_q, is_read_d;
   logic                   scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
   logic [7:0]             shift_in, tx_byte;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

`ifdef I2C_TARGET_STRETCH_EN
   logic scl_drv_q, scl_drv_d;
   assign bus.scl_drive_low = scl_drv_q;
`else
   assign bus.scl_drive_low = 1'b0;
`endif

   assign bus.sda_drive_low = sda_drv_q;
   assign bus.rx_data       = rx_data_q;
   assign bus.rx_valid      = rx_valid_q;
   assign bus.tx_taken      = tx_taken_q;
   assign bus.tx_underrun   = tx_underrun_q;
   assign bus.busy          = busy_q;
   assign bus.addressed     = addressed_q;
   assign bus.is_read       = is_read_q;

   always_comb begin
      scl_sync_d    = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_d    = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev_d    = scl_s;
      sda_prev_d    = sda_s;
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      ack_ph_d      = ack_ph_q;
      sda_drv_d     = sda_drv_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_taken_d    = 1'b0;
      tx_underrun_d = 1'b0;
      busy_d        = busy_q;
      addressed_d   = addressed_q;
      is_read_d     = is_read_q;
      shift_in      = {shift_q[6:0], sda_s};
      tx_byte       = bus.tx_valid ? bus.tx_data : 8'hFF;
`ifdef I2C_TARGET_STRETCH_EN
      scl_drv_d     = 1'b0;
`endif

      unique case (state_q)
         S_ADDR: if (scl_rise) begin
            shift_d = shift_in;
            if (cnt_q == 3'd0) begin
               if (shift_in[7:1] == bus.own_address) begin
                  is_read_d = shift_in[0];
                  state_d   = S_ADDR_ACK;
               end else begin
                  state_d = S_WAIT_STOP;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         // first fall starts the ACK low period, second fall ends it
         S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
            if (!ack_ph_q) begin
               sda_drv_d = 1'b1;
               ack_ph_d  = 1'b1;
               if (state_q == S_ADDR_ACK) addressed_d = 1'b1;
            end else begin
               sda_drv_d = 1'b0;
               ack_ph_d  = 1'b0;
               cnt_d     = 3'd7;
               state_d   = (state_q == S_ADDR_ACK && is_read_q) ? S_TX_LOAD : S_RX_BYTE;
            end
         end
         S_RX_BYTE: if (scl_rise) begin
            shift_d = shift_in;
            if (cnt_q == 3'd0) begin
               rx_data_d  = shift_in;
               rx_valid_d = 1'b1;
               state_d    = S_RX_ACK;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_TX_LOAD: begin
`ifdef I2C_TARGET_STRETCH_EN
            if (bus.tx_valid) begin
               shift_d    = tx_byte;
               tx_taken_d = 1'b1;
               sda_drv_d  = ~tx_byte[7];
               cnt_d      = 3'd7;
               scl_drv_d  = scl_drv_q;
               state_d    = S_TX_BYTE;
            end else begin
               scl_drv_d = 1'b1;
            end
`else
            shift_d       = tx_byte;
            tx_taken_d    = bus.tx_valid;
            tx_underrun_d = ~bus.tx_valid;
            sda_drv_d     = ~tx_byte[7];
            cnt_d         = 3'd7;
            state_d       = S_TX_BYTE;
`endif
         end
         S_TX_BYTE: if (scl_fall) begin
            if (cnt_q == 3'd0) begin
               sda_drv_d = 1'b0;
               ack_ph_d  = 1'b0;
               state_d   = S_TX_ACK;
            end else begin
               shift_d   = {shift_q[6:0], 1'b0};
               sda_drv_d = ~shift_q[6];
               cnt_d     = cnt_q - 3'd1;
            end
         end
         // shift_q[0] holds the sampled ACK bit (1 = NACK)
         S_TX_ACK: begin
            if (scl_rise) begin
               shift_d[0] = sda_s;
               ack_ph_d   = 1'b1;
            end else if (scl_fall && ack_ph_q) begin
               ack_ph_d = 1'b0;
               state_d  = shift_q[0] ? S_WAIT_STOP : S_TX_LOAD;
            end
         end
         S_IDLE, S_WAIT_STOP: ;
         default: state_d = S_IDLE;
      endcase

      if (start_ev || stop_ev) begin
         state_d       = start_ev ? S_ADDR : S_IDLE;
         busy_d        = start_ev;
         cnt_d         = 3'd7;
         ack_ph_d      = 1'b0;
         sda_drv_d     = 1'b0;
         addressed_d   = 1'b0;
         rx_valid_d    = 1'b0;
         tx_taken_d    = 1'b0;
         tx_underrun_d = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
         scl_drv_d     = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         scl_sync_q    <= '1;
         sda_sync_q    <= '1;
         scl_prev_q    <= 1'b1;
         sda_prev_q    <= 1'b1;
         state_q       <= S_IDLE;
         shift_q       <= 8'h00;
         cnt_q         <= 3'd0;
         ack_ph_q      <= 1'b0;
         sda_drv_q     <= 1'b0;
         rx_data_q     <= 8'h00;
         rx_valid_q    <= 1'b0;
         tx_taken_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         busy_q        <= 1'b0;
         addressed_q   <= 1'b0;
         is_read_q     <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
         scl_drv_q     <= 1'b0;
`endif
      end else begin
         scl_sync_q    <= scl_sync_d;
         sda_sync_q    <= sda_sync_d;
         scl_prev_q    <= scl_prev_d;
         sda_prev_q    <= sda_prev_d;
         state_q       <= state_d;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         ack_ph_q      <= ack_ph_d;
         sda_drv_q     <= sda_drv_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_taken_q    <= tx_taken_d;
         tx_underrun_q <= tx_underrun_d;
         busy_q        <= busy_d;
         addressed_q   <= addressed_d;
         is_read_q     <= is_read_d;
`ifdef I2C_TARGET_STRETCH_EN
         scl_drv_q     <= scl_drv_d;
`endif
      end
   end
endmodule
